fp_mmio_queue: RTL
==================

Name: fp_mmio_queue

Overview:
- Parametrised memory-mapped front end for the FP multiply core, replacing the single-shot operand/start/done register set.
- Software pushes operand pairs into a job queue. An internal sequencer issues jobs to the core one at a time and collects products plus the 6 exception flags into a result queue.
- Software pops results in order without waiting on each operation.
- Sits on the processor data bus beside other memory-mapped peripherals.

Parameters:
- WIDTH, 32, operand/result width and bus data width.
- DEPTH, 4, entries in each of the job queue and the result queue; legal range 2..15.
- CNT_W, $clog2(DEPTH+1), occupancy counter width; derived, never overridden.

Ports:
- Clk  in  1  clock.
- Rst  in  1  asynchronous, active-high reset.
- A  in  3  word address.
- WE  in  1  bus write strobe.
- RE  in  1  bus read strobe; used only for pop side effects.
- InData  in  WIDTH  bus write data.
- OutData  out  WIDTH  bus read data; combinational from A.
- core_start  out  1  one-cycle start pulse to the core.
- core_a  out  WIDTH  operand A of the job in flight.
- core_b  out  WIDTH  operand B of the job in flight.
- core_done  in  1  core completion pulse.
- core_p  in  WIDTH  core product; valid when core_done=1.
- core_flags  in  6  {OF,UF,NANF,INFF,DNF,ZF}; valid when core_done=1.
- irq  out  1  high while the result queue is non-empty and CTRL.ie=1.

Behaviour:
- Register map:
  - 0: OPA (R/W staging).
  - 1: OPB (R/W staging).
  - 2: CTRL.
  - 3: STATUS (R).
  - 4: RESULT (R; pops).
  - 5: RFLAGS (R; no pop).
  - 6, 7: read 0; writes ignored.
- CTRL write bits:
  - [16] push {OPA,OPB} into the job queue.
  - [8] clear the sticky errors.
  - [0] ie, stored.
  - Push and clear may occur in the same write.
  - CTRL reads back {15'b0, 0, 7'b0, 0, 7'b0, ie}.
- STATUS bits:
  - [0] res_valid.
  - [1] busy (sequencer not IDLE).
  - [2] job_full.
  - [3] ovf_err (sticky).
  - [4] unf_err (sticky).
  - [8 +: CTRL... CNT_W] job_cnt, i.e. job_cnt at [8 +: CNT_W].
  - [16 +: CNT_W] res_cnt.
- RFLAGS returns the head result's {tag[3:0], 2'b0, flags[5:0]} in [11:0]. The tag is a 4-bit job sequence number assigned at push, incrementing mod 16, 0 after reset.
- RESULT read returns the head product. The pop occurs on the clock edge where RE=1 and A=4.
- Reset values: all queues empty; counters 0; tag 0; OPA, OPB, ie, errors 0; sequencer IDLE; core_start 0; irq 0. Rst mid-job abandons the job. A later stray core_done is ignored because the sequencer is in IDLE.
- Sequencer states:
  - IDLE: if the job queue is non-empty and res_cnt < DEPTH, latch the head into core_a/core_b, pop the job, and go to ISSUE.
  - ISSUE: core_start=1 for exactly one cycle, then go to WAIT.
  - WAIT: hold core_a/core_b stable until core_done, then capture {core_p, core_flags, tag} and go to WB.
  - WB: push the capture into the result queue, then go to IDLE.
  - Minimum issue-to-issue interval is core latency + 3 cycles.
- Backpressure: the IDLE-state check guarantees the WB push never overflows the result queue.
- Job push while job_full: data dropped, tag not advanced, ovf_err set.
- Pop while the result queue is empty: OutData=0, no state change, unf_err set.
- Simultaneous events in one cycle:
  - Job push + sequencer pop: job_cnt unchanged; both take effect.
  - WB push + bus pop: res_cnt unchanged; both take effect.
  - Error set + clear in the same cycle: set wins.
- Staging registers persist after a push, so repeated pushes reuse the operands.
- Pointers wrap mod DEPTH. Full/empty is decided by the counters, not by pointer equality.
- OutData for RESULT/RFLAGS reflects the head before that cycle's pop.

Decomposition:
- Package fp_mmio_pkg holds:
  - Address constants ADDR_OPA..ADDR_RFLAGS.
  - CTRL/STATUS bit-position constants.
  - Sequencer state enum {IDLE, ISSUE, WAIT, WB}.
  - Flag-vector width constant 6.
- Sub-module fp_sync_fifo, parameters WIDTH and DEPTH; ports Clk, Rst, push, pop, din, dout, count, full, empty. It is instantiated twice:
  - Job queue: width 2*WIDTH+4.
  - Result queue: width WIDTH+10.

Test Plan:
- Basic product: OPA=0x3FC00000, OPB=0x40000000, CTRL=0x10000; core model latency 5. Required: one core_start pulse; STATUS[0]=1 within 10 cycles; RFLAGS=0x000; RESULT=0x40400000; then res_cnt=0.
- Burst: 4 pushes with OPB=0x40000000 and OPA=1.0, 2.0, 3.0, 4.0. Required: results 0x40000000, 0x40800000, 0x40C00000, 0x41000000 in order; tags 0..3; one job in flight at any time.
- Overflow: hold core_done low and push 6 jobs. Required: 1 job in flight, job_cnt=4, job_full=1, ovf_err=1, tag=5. Write CTRL=0x100; required: ovf_err=0.
- Result backpressure: push 5 jobs without reading. Required: res_cnt=4, job_cnt=1, no further core_start. One RESULT pop; required: the next job issues within 1 cycle.
- Underflow and simultaneous events: read RESULT while empty; required: OutData=0, unf_err=1. Separately, align a RESULT pop with the WB cycle; required: res_cnt unchanged.
- Async reset: assert Rst during WAIT, then deassert. Required: every STATUS field 0, core_start 0; a delayed core_done produces no result.

Source files
------------

// File: rtl/fp_mmio_pkg.sv
// fp_mmio_pkg: shared constants and types for the FP multiply MMIO queue.
// No ports; register map, bit positions and the sequencer state type.
package fp_mmio_pkg;

    localparam logic [2:0] ADDR_OPA    = 3'd0;
    localparam logic [2:0] ADDR_OPB    = 3'd1;
    localparam logic [2:0] ADDR_CTRL   = 3'd2;
    localparam logic [2:0] ADDR_STATUS = 3'd3;
    localparam logic [2:0] ADDR_RESULT = 3'd4;
    localparam logic [2:0] ADDR_RFLAGS = 3'd5;

    localparam int CTRL_PUSH = 16;
    localparam int CTRL_CLR  = 8;
    localparam int CTRL_IE   = 0;

    localparam int ST_RES_VALID = 0;
    localparam int ST_BUSY      = 1;
    localparam int ST_JOB_FULL  = 2;
    localparam int ST_OVF       = 3;
    localparam int ST_UNF       = 4;
    localparam int ST_JOB_CNT   = 8;
    localparam int ST_RES_CNT   = 16;

    localparam int FLAG_W = 6;
    localparam int TAG_W  = 4;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        WB
    } seq_state_t;

endpackage

// File: rtl/fp_sync_fifo.sv
// fp_sync_fifo: counter-based synchronous FIFO, push/pop ignored when full/empty.
// Ports: Clk, Rst (async, high), push, pop, din, dout (head), count, full, empty.
module fp_sync_fifo
    import fp_mmio_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] inc(
        input logic [PTR_W-1:0] p
    );
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge Clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= inc(rd_ptr);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fp_mmio_queue.sv
// fp_mmio_queue: MMIO job/result queues and sequencer for the FP multiply core.
// Ports: Clk, Rst, bus (A, WE, RE, InData, OutData), core_* handshake, irq.
module fp_mmio_queue
    import fp_mmio_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [2:0]        A,
    input  logic              WE,
    input  logic              RE,
    input  logic [WIDTH-1:0]  InData,
    output logic [WIDTH-1:0]  OutData,
    output logic              core_start,
    output logic [WIDTH-1:0]  core_a,
    output logic [WIDTH-1:0]  core_b,
    input  logic              core_done,
    input  logic [WIDTH-1:0]  core_p,
    input  logic [FLAG_W-1:0] core_flags,
    output logic              irq
);

    localparam int JW = 2 * WIDTH + TAG_W;
    localparam int RW = WIDTH + FLAG_W + TAG_W;

    logic [WIDTH-1:0]  opa;
    logic [WIDTH-1:0]  opb;
    logic              ie;
    logic              ovf_err;
    logic              unf_err;
    logic [TAG_W-1:0]  tag;

    logic              ctrl_wr;
    logic              push_req;
    logic              clr_req;
    logic              pop_req;
    logic              job_push;
    logic              res_pop;
    logic              ovf_set;
    logic              unf_set;

    logic [JW-1:0]     job_dout;
    logic [CNT_W-1:0]  job_cnt;
    logic              job_full;
    logic              job_empty;

    logic [RW-1:0]     res_din;
    logic [RW-1:0]     res_dout;
    logic [CNT_W-1:0]  res_cnt;
    logic              res_full;
    logic              res_empty;
    logic [TAG_W-1:0]  res_tag;
    logic [FLAG_W-1:0] res_flags;
    logic [WIDTH-1:0]  res_p;

    seq_state_t        state;
    seq_state_t        state_nxt;
    logic              job_pop;
    logic              cap_en;
    logic              res_push;
    logic [TAG_W-1:0]  run_tag;
    logic [WIDTH-1:0]  cap_p;
    logic [FLAG_W-1:0] cap_flags;
    logic [WIDTH-1:0]  status;

    assign ctrl_wr  = WE && (A == ADDR_CTRL);
    assign push_req = ctrl_wr && InData[CTRL_PUSH];
    assign clr_req  = ctrl_wr && InData[CTRL_CLR];
    assign pop_req  = RE && (A == ADDR_RESULT);
    assign job_push = push_req && !job_full;
    assign ovf_set  = push_req && job_full;
    assign res_pop  = pop_req && !res_empty;
    assign unf_set  = pop_req && res_empty;

    assign irq = ie && !res_empty;

    fp_sync_fifo #(
        .WIDTH (JW),
        .DEPTH (DEPTH)
    ) u_job_q (
        .Clk   (Clk),
        .Rst   (Rst),
        .push  (job_push),
        .pop   (job_pop),
        .din   ({tag, opa, opb}),
        .dout  (job_dout),
        .count (job_cnt),
        .full  (job_full),
        .empty (job_empty)
    );

    assign res_din = {run_tag, cap_flags, cap_p};

    fp_sync_fifo #(
        .WIDTH (RW),
        .DEPTH (DEPTH)
    ) u_res_q (
        .Clk   (Clk),
        .Rst   (Rst),
        .push  (res_push),
        .pop   (res_pop),
        .din   (res_din),
        .dout  (res_dout),
        .count (res_cnt),
        .full  (res_full),
        .empty (res_empty)
    );

    assign {res_tag, res_flags, res_p} = res_dout;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            opa     <= '0;
            opb     <= '0;
            ie      <= 1'b0;
            ovf_err <= 1'b0;
            unf_err <= 1'b0;
            tag     <= '0;
        end else begin
            if (WE && (A == ADDR_OPA)) begin
                opa <= InData;
            end
            if (WE && (A == ADDR_OPB)) begin
                opb <= InData;
            end
            if (ctrl_wr) begin
                ie <= InData[CTRL_IE];
            end
            // A dropped push does not consume a tag.
            if (job_push) begin
                tag <= tag + 1'b1;
            end
            // Setting beats clearing in the same cycle.
            if (ovf_set) begin
                ovf_err <= 1'b1;
            end else if (clr_req) begin
                ovf_err <= 1'b0;
            end
            if (unf_set) begin
                unf_err <= 1'b1;
            end else if (clr_req) begin
                unf_err <= 1'b0;
            end
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Issue only with a free result slot, so the WB push
    // can never be dropped.
    always_comb begin
        state_nxt  = state;
        core_start = 1'b0;
        job_pop    = 1'b0;
        cap_en     = 1'b0;
        res_push   = 1'b0;
        unique case (state)
            IDLE: begin
                if (!job_empty && !res_full) begin
                    job_pop   = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                core_start = 1'b1;
                state_nxt  = WAIT;
            end
            WAIT: begin
                if (core_done) begin
                    cap_en    = 1'b1;
                    state_nxt = WB;
                end
            end
            WB: begin
                res_push  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // core_a/core_b stay put from issue until the next
    // job is taken in IDLE, covering the whole WAIT.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            run_tag   <= '0;
            core_a    <= '0;
            core_b    <= '0;
            cap_p     <= '0;
            cap_flags <= '0;
        end else begin
            if (job_pop) begin
                {run_tag, core_a, core_b} <= job_dout;
            end
            if (cap_en) begin
                cap_p     <= core_p;
                cap_flags <= core_flags;
            end
        end
    end

    always_comb begin
        status                          = '0;
        status[ST_RES_VALID]            = !res_empty;
        status[ST_BUSY]                 = (state != IDLE);
        status[ST_JOB_FULL]             = job_full;
        status[ST_OVF]                  = ovf_err;
        status[ST_UNF]                  = unf_err;
        status[ST_JOB_CNT +: CNT_W]     = job_cnt;
        status[ST_RES_CNT +: CNT_W]     = res_cnt;
    end

    // Head reads show the entry before this cycle's pop;
    // an empty queue reads as zero.
    always_comb begin
        OutData = '0;
        unique case (A)
            ADDR_OPA:    OutData = opa;
            ADDR_OPB:    OutData = opb;
            ADDR_CTRL:   OutData[CTRL_IE] = ie;
            ADDR_STATUS: OutData = status;
            ADDR_RESULT: begin
                if (!res_empty) begin
                    OutData = res_p;
                end
            end
            ADDR_RFLAGS: begin
                if (!res_empty) begin
                    OutData[11:0] = {res_tag, 2'b00, res_flags};
                end
            end
            default: OutData = '0;
        endcase
    end

endmodule
